// File: rtl/itcm_arbiter_if.sv
// ITCM requester port: command and response channels.
// One instance per requester (IFU, LSU).
interface itcm_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [MW-1:0] cmd_wmask;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wmask, cmd_wdata,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wmask, cmd_wdata,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/itcm_arbiter.sv
// Round-robin arbiter sharing the single-port ITCM SRAM between IFU and LSU.
// One outstanding transaction; stalled responses park in a hold buffer.
module itcm_arbiter #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    itcm_arbiter_if.slave ifu,
    itcm_arbiter_if.slave lsu,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    // owner/last_grant encoding: 0 = IFU, 1 = LSU
    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] hold_q, hold_d;

    logic          pend;
    logic          own_rdy;
    logic          arb_en;
    logic          gnt_ifu, gnt_lsu;
    logic          acc_ifu, acc_lsu;
    logic          accept;
    logic          sel_read;
    logic [DW-1:0] live_data;
    logic [DW-1:0] rsp_data;

    assign pend    = (state_q != IDLE);
    assign own_rdy = owner_q ? lsu.rsp_ready : ifu.rsp_ready;
    assign arb_en  = (state_q == IDLE) | (own_rdy & pend);

    // On contention the requester that did not win last time goes first
    assign gnt_ifu = ifu.cmd_valid & (~lsu.cmd_valid | last_q);
    assign gnt_lsu = lsu.cmd_valid & (~ifu.cmd_valid | ~last_q);

    assign ifu.cmd_ready = arb_en & gnt_ifu;
    assign lsu.cmd_ready = arb_en & gnt_lsu;

    assign acc_ifu = ifu.cmd_valid & ifu.cmd_ready;
    assign acc_lsu = lsu.cmd_valid & lsu.cmd_ready;
    assign accept  = acc_ifu | acc_lsu;

    assign sel_read = acc_lsu ? lsu.cmd_read : ifu.cmd_read;

    assign ram_cs   = accept;
    assign ram_we   = accept & ~sel_read;
    assign ram_addr = acc_lsu ? lsu.cmd_addr  : ifu.cmd_addr;
    assign ram_wem  = acc_lsu ? lsu.cmd_wmask : ifu.cmd_wmask;
    assign ram_din  = acc_lsu ? lsu.cmd_wdata : ifu.cmd_wdata;

    assign live_data = wr_q ? '0 : ram_dout;
    assign rsp_data  = (state_q == HOLD) ? hold_q : live_data;

    assign ifu.rsp_valid = pend & ~owner_q;
    assign lsu.rsp_valid = pend & owner_q;
    assign ifu.rsp_rdata = ifu.rsp_valid ? rsp_data : '0;
    assign lsu.rsp_rdata = lsu.rsp_valid ? rsp_data : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        hold_d  = hold_q;
        if (accept) begin
            owner_d = acc_lsu;
            last_d  = acc_lsu;
            wr_d    = ~sel_read;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY, HOLD: begin
                if (own_rdy) begin
                    state_d = accept ? BUSY : IDLE;
                end else if (state_q == BUSY) begin
                    // dout is only valid this cycle; park it
                    state_d = HOLD;
                    hold_d  = live_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_itcm_arbiter.sv
// Scoreboard bench for itcm_arbiter with a behavioural SRAM.
// Expected RAM ops and responses are queued at issue time.
module tb_itcm_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = 4;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct packed {
        logic          src;
        logic          we;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        logic [DW-1:0] d;
    } ram_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    itcm_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) ifu ();
    itcm_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) lsu ();

    itcm_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ifu      (ifu),
        .lsu      (lsu),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wem  (ram_wem),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    cmd_t          ifu_q[$];
    cmd_t          lsu_q[$];
    ram_t          exp_ram[$];
    logic [DW-1:0] exp_ifu[$];
    logic [DW-1:0] exp_lsu[$];
    logic          ifu_fire = 1'b0;
    logic          lsu_fire = 1'b0;

    logic [DW-1:0] mem [0:255];

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", n, act, exp);
    endtask

    // Behavioural SRAM: dout is garbage unless a read was issued last cycle
    always @(posedge clk) begin
        if (ram_cs && !ram_we) begin
            ram_dout <= mem[ram_addr[7:0]];
        end else begin
            ram_dout <= 32'hFFFF_FFFF;
        end
        if (ram_cs && ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_wem[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
    end

    // Requester drivers: present queue heads, pop on handshake
    always @(posedge clk) begin
        #1;
        if (ifu_fire && ifu_q.size() > 0) void'(ifu_q.pop_front());
        if (lsu_fire && lsu_q.size() > 0) void'(lsu_q.pop_front());
        ifu.cmd_valid = (ifu_q.size() > 0);
        lsu.cmd_valid = (lsu_q.size() > 0);
        if (ifu_q.size() > 0) begin
            ifu.cmd_read  = ifu_q[0].rd;
            ifu.cmd_addr  = ifu_q[0].a;
            ifu.cmd_wmask = ifu_q[0].m;
            ifu.cmd_wdata = ifu_q[0].d;
        end
        if (lsu_q.size() > 0) begin
            lsu.cmd_read  = lsu_q[0].rd;
            lsu.cmd_addr  = lsu_q[0].a;
            lsu.cmd_wmask = lsu_q[0].m;
            lsu.cmd_wdata = lsu_q[0].d;
        end
    end

    // Monitor: compare RAM ops and responses against the scoreboard
    always @(negedge clk) begin
        ram_t e;
        ifu_fire = ifu.cmd_valid & ifu.cmd_ready;
        lsu_fire = lsu.cmd_valid & lsu.cmd_ready;
        if (rst_n) begin
            if (ram_cs) begin
                if (exp_ram.size() == 0) begin
                    chk("ram_unexp", ram_cs, 0);
                end else begin
                    e = exp_ram.pop_front();
                    chk("ram_src", lsu_fire, e.src);
                    chk("ram_we", ram_we, e.we);
                    chk("ram_addr", ram_addr, e.a);
                    if (e.we) begin
                        chk("ram_wem", ram_wem, e.m);
                        chk("ram_din", ram_din, e.d);
                    end
                end
            end
            if (ifu.rsp_valid) begin
                if (exp_ifu.size() == 0) begin
                    chk("ifu_unexp", ifu.rsp_valid, 0);
                end else begin
                    chk("ifu_rdata", ifu.rsp_rdata, exp_ifu[0]);
                    if (ifu.rsp_ready) void'(exp_ifu.pop_front());
                end
            end
            if (lsu.rsp_valid) begin
                if (exp_lsu.size() == 0) begin
                    chk("lsu_unexp", lsu.rsp_valid, 0);
                end else begin
                    chk("lsu_rdata", lsu.rsp_rdata, exp_lsu[0]);
                    if (lsu.rsp_ready) void'(exp_lsu.pop_front());
                end
            end
        end
    end

    task automatic issue(bit src, bit rd, logic [AW-1:0] a, logic [MW-1:0] m,
                         logic [DW-1:0] d, logic [DW-1:0] rsp);
        cmd_t c;
        ram_t r;
        c = '{rd: rd, a: a, m: m, d: d};
        r = '{src: src, we: ~rd, a: a, m: m, d: d};
        exp_ram.push_back(r);
        if (src) begin
            lsu_q.push_back(c);
            exp_lsu.push_back(rsp);
        end else begin
            ifu_q.push_back(c);
            exp_ifu.push_back(rsp);
        end
    endtask

    function automatic bit busy();
        return (ifu_q.size() + lsu_q.size() + exp_ram.size()
                + exp_ifu.size() + exp_lsu.size()) != 0;
    endfunction

    task automatic wait_empty(int lim);
        int n = 0;
        while (busy() && n < lim) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= lim) chk("timeout", busy(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[16] = 32'hDEAD_BEEF;
        ifu.cmd_valid = 1'b0; ifu.cmd_read = 1'b1; ifu.cmd_addr = '0;
        ifu.cmd_wmask = '0;   ifu.cmd_wdata = '0;  ifu.rsp_ready = 1'b1;
        lsu.cmd_valid = 1'b0; lsu.cmd_read = 1'b1; lsu.cmd_addr = '0;
        lsu.cmd_wmask = '0;   lsu.cmd_wdata = '0;  lsu.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_cs", ram_cs, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ifu_valid", ifu.rsp_valid, 0);
        chk("rst_lsu_valid", lsu.rsp_valid, 0);
        chk("rst_ifu_ready", ifu.cmd_ready, 0);
        rst_n = 1'b1;
        #2;

        // Single IFU read
        issue(0, 1, 14'h010, 4'h0, 32'h0, 32'hDEAD_BEEF);
        n = 0;
        while (!ram_cs && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t1_cs", ram_cs, 1);
        chk("t1_we", ram_we, 0);
        chk("t1_addr", ram_addr, 14'h010);
        @(negedge clk);
        chk("t1_ifu_valid", ifu.rsp_valid, 1);
        chk("t1_lsu_valid", lsu.rsp_valid, 0);
        wait_empty(50);

        // Contention: IFU first after reset, then strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(0, 1, 14'(8 + i), 4'h0, 32'h0, 32'h1000_0008 + i);
            issue(1, 1, 14'(12 + i), 4'h0, 32'h0, 32'h1000_000C + i);
        end
        wait_empty(100);

        // LSU partial write, then read back through the same path
        issue(1, 0, 14'h020, 4'b0011, 32'h1234_5678, 32'h0);
        issue(1, 1, 14'h020, 4'h0, 32'h0, 32'h1000_5678);
        wait_empty(50);

        // IFU response stalled three cycles while an LSU command waits
        ifu.rsp_ready = 1'b0;
        issue(0, 1, 14'h005, 4'h0, 32'h0, 32'h1000_0005);
        n = 0;
        while (ifu_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("hold_accept", ifu_q.size(), 0);
        issue(1, 1, 14'h006, 4'h0, 32'h0, 32'h1000_0006);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_valid", ifu.rsp_valid, 1);
            chk("hold_ifu_rdy", ifu.cmd_ready, 0);
            chk("hold_lsu_rdy", lsu.cmd_ready, 0);
            chk("hold_cs", ram_cs, 0);
        end
        @(posedge clk);
        #1;
        ifu.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_lsu_rdy", lsu.cmd_ready, 1);
        chk("release_cs", ram_cs, 1);
        #2;
        wait_empty(50);

        // Reset while a stalled response is held
        ifu.rsp_ready = 1'b0;
        issue(0, 1, 14'h030, 4'h0, 32'h0, 32'h1000_0030);
        n = 0;
        while (ifu_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        @(negedge clk);
        #2;
        chk("pre_rst_valid", ifu.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", ifu.rsp_valid, 0);
        chk("rst_drop_lsu", lsu.rsp_valid, 0);
        exp_ifu.delete();
        ifu.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        issue(0, 1, 14'h040, 4'h0, 32'h0, 32'h1000_0040);
        issue(1, 1, 14'h041, 4'h0, 32'h0, 32'h1000_0041);
        wait_empty(50);

        // IFU back-to-back reads, one accept per cycle
        for (int i = 0; i < 8; i++) begin
            issue(0, 1, 14'(i), 4'h0, 32'h0, 32'h1000_0000 + i);
        end
        n = 0;
        while (!ram_cs && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first", ram_cs, 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_cs", ram_cs, 1);
            chk("b2b_valid", ifu.rsp_valid, 1);
        end
        #2;
        wait_empty(50);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
